reconstroi_operando: RTL and testbench
======================================

Name: reconstroi_operando

Overview:
Inverse of the magnitude-difference unit. Given operand A, magnitude S = |A-B| and sign flag sinal (1 = A<B), it reconstructs operand B.
- sinal=0: B = A - S
- sinal=1: B = A + S
Computation is bit-serial, LSB first, through a single full adder/subtractor cell, with a start/done handshake. It sits on the checking path after the difference datapath and rebuilds B so it can be compared against the original.

Parameters:
WIDTH, 4, operand width in bits (A, S, B); minimum 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in OCIOSO
A  input  WIDTH  known operand
S  input  WIDTH  magnitude of difference
sinal  input  1  sign of difference; 1 = negative (A<B)
B  output  WIDTH  reconstructed operand; registered
erro  output  1  inputs inconsistent or result out of range; registered
busy  output  1  high in CALCULA and FIM
done  output  1  one-cycle pulse; B and erro valid

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst; every register updates only on the rising edge of clk.
- Reset values: B=0, erro=0, busy=0, done=0; state OCIOSO; bit counter=0; carry/borrow flop=0; operand shift registers=0.
- rst has priority over all other inputs in every state. Reset mid-operation aborts the operation, and no done pulse is produced.
- States:
  - OCIOSO: start=1 at edge E0 latches A, S and sinal into internal shift registers, clears carry/borrow and counter, then -> CALCULA. start=0 stays in OCIOSO.
  - CALCULA: at edge E(i+1), i=0..WIDTH-1, bit i is computed:
    - sinal=0: r_i = a_i XOR s_i XOR borrow; borrow' = (~a_i & s_i) | (~(a_i XOR s_i) & borrow).
    - sinal=1: r_i = a_i XOR s_i XOR carry; carry' = majority(a_i, s_i, carry).
    - The result bit shifts into the result register MSB side; the operand registers shift right.
    - After the last bit (edge E(WIDTH)) -> FIM.
  - FIM: entered at E(WIDTH). In that same edge, B := full result and erro := final carry/borrow OR (sinal AND S==0), and done=1 for exactly this cycle. Next edge -> OCIOSO, done=0.
- Latency: done is high in the cycle following edge E(WIDTH), WIDTH edges after start is sampled; total occupancy is WIDTH+1 cycles.
- B and erro hold their values from FIM until the next FIM or rst. They do not change during CALCULA.
- Arithmetic is modulo 2^WIDTH. On overflow or borrow, B is the wrapped result and erro=1.
  - Example, WIDTH=4: A=12, S=6, sinal=1 -> B=2, erro=1.
- sinal=1 with S=0 is contradictory (a negative sign requires a nonzero difference), so erro=1 and B=A.
- sinal=0 with S=0 gives B=A, erro=0.
- start while busy is ignored; no queuing. start held high continuously restarts in the cycle after FIM returns to OCIOSO.
- Input changes after E0 do not affect the operation in progress.

Decomposition:
- Shared package: state encoding constants OCIOSO=2'b00, CALCULA=2'b01, FIM=2'b10; default width constant 4; counter width derived as clog2(WIDTH).
- One natural sub-module: somasub_bit.
  - Combinational 1-bit full adder/subtractor.
  - Inputs: a, s, cin, modo (0 = subtract, 1 = add). Outputs: r, cout.
  - Instantiated once inside the serial datapath.
- The FSM, counter and shift registers stay in reconstroi_operando.

Test Plan:
1. rst, then A=9, S=3, sinal=0, start pulse -> busy high; done at E4; B=6, erro=0; busy low after E5.
2. A=2, S=5, sinal=1 -> B=7, erro=0; B holds at 7 for 10 idle cycles after done.
3. A=3, S=5, sinal=0 (borrow) -> B=14, erro=1. A=12, S=6, sinal=1 (carry) -> B=2, erro=1.
4. A=5, S=0, sinal=1 -> B=5, erro=1. A=5, S=0, sinal=0 -> B=5, erro=0.
5. Start A=9, S=3, sinal=0. Pulse start with A=1, S=1, sinal=1 at E2 and change A at E2 -> result still B=6, done only once.
6. Start an operation, assert rst at E2 -> next cycle all outputs 0, state OCIOSO, no done. Then start A=15, S=15, sinal=0 -> B=0, erro=0.

Source files
------------

// File: rtl/reconstroi_operando_pkg.sv
// Shared constants for the bit-serial operand reconstruction unit.
// Holds the state encoding, the default width and the counter width helper.
package reconstroi_operando_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/reconstroi_operando_somasub_bit.sv
// Combinational 1-bit full adder / subtractor.
// modo=1 adds (cout is carry), modo=0 subtracts s from a (cout is borrow).
module somasub_bit (
  input  logic a,
  input  logic s,
  input  logic cin,
  input  logic modo,
  output logic r,
  output logic cout
);

  logic w_carry;
  logic w_borrow;

  assign r        = a ^ s ^ cin;
  assign w_carry  = (a & s) | (a & cin) | (s & cin);
  assign w_borrow = (~a & s) | (~(a ^ s) & cin);
  assign cout     = modo ? w_carry : w_borrow;

endmodule

// File: rtl/reconstroi_operando.sv
// Rebuilds operand B from A, |A-B| and the sign flag, one bit per cycle LSB first.
// state   | meaning
// OCIOSO  | idle, waiting for start
// CALCULA | one result bit per cycle through the serial adder/subtractor
// FIM     | done pulse cycle, result and error flag just registered
module reconstroi_operando
  import reconstroi_operando_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] S,
  input  logic             sinal,
  output logic [WIDTH-1:0] B,
  output logic             erro,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

  estado_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_sinal;
  logic             r_s_zero;
  logic [WIDTH-1:0] r_b;
  logic             r_erro;
  logic             r_busy;
  logic             r_done;

  logic             w_r;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  somasub_bit u_somasub (
    .a    (r_a[0]),
    .s    (r_s[0]),
    .cin  (r_c),
    .modo (r_sinal),
    .r    (w_r),
    .cout (w_cout)
  );

  assign w_res_next = {w_r, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= OCIOSO;
      r_a      <= '0;
      r_s      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_sinal  <= 1'b0;
      r_s_zero <= 1'b0;
      r_b      <= '0;
      r_erro   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        OCIOSO: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= A;
            r_s      <= S;
            r_sinal  <= sinal;
            r_s_zero <= (S == '0);
            r_res    <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALCULA;
          end
        end
        CALCULA: begin
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_s   <= r_s >> 1;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == ULTIMO) begin
            // S itself has been shifted out, so the zero test uses the flag captured at start
            r_b     <= w_res_next;
            r_erro  <= w_cout | (r_sinal & r_s_zero);
            r_done  <= 1'b1;
            r_state <= FIM;
          end
        end
        FIM: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= OCIOSO;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= OCIOSO;
        end
      endcase
    end
  end

  assign B    = r_b;
  assign erro = r_erro;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_reconstroi_operando.sv
// Self-checking bench for reconstroi_operando: arithmetic reference model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_reconstroi_operando;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] S = '0;
  logic         sinal = 1'b0;
  logic [W-1:0] B;
  logic         erro;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  reconstroi_operando #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .S     (S),
    .sinal (sinal),
    .B     (B),
    .erro  (erro),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // reference model: timing from the latency rules, result from plain integer arithmetic
  bit   m_busy = 0, m_done = 0, m_erro = 0, e_erro = 0;
  int   m_b = 0, e_b = 0, m_cyc = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_b = 0; m_erro = 0; m_cyc = 0;
    end else if (!m_busy) begin
      if (start) begin
        int a_i, s_i;
        a_i = int'(A); s_i = int'(S);
        if (sinal) begin
          e_b    = (a_i + s_i) % (1 << W);
          e_erro = ((a_i + s_i) >= (1 << W)) || (s_i == 0);
        end else begin
          e_b    = (a_i - s_i + (1 << W)) % (1 << W);
          e_erro = (a_i < s_i);
        end
        m_busy = 1; m_cyc = 0;
      end
    end else begin
      m_cyc++;
      if (m_cyc == W) begin
        m_done = 1; m_b = e_b; m_erro = e_erro;
      end else if (m_cyc == W + 1) begin
        m_done = 0; m_busy = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 8'(busy), 8'(m_busy));
      chk("model_done", 8'(done), 8'(m_done));
      chk("model_B",    8'(B),    8'(m_b));
      chk("model_erro", 8'(erro), 8'(m_erro));
    end
  end

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL done_timeout at %0t: got no done expected done within 30 cycles", $time);
    end
  endtask

  task automatic run_op(input int a, input int s, input bit sg, input int exp_b, input bit exp_e);
    bit ok;
    @(negedge clk);
    A = W'(a); S = W'(s); sinal = sg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lit_busy_started", 8'(busy), 8'd1);
    wait_done(ok);
    if (ok) begin
      chk("lit_B",    8'(B),    8'(exp_b));
      chk("lit_erro", 8'(erro), 8'(exp_e));
    end
  endtask

  initial begin
    bit ok;
    int ndone;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_B", 8'(B), 8'd0);
    chk("rst_erro", 8'(erro), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    rst = 1'b0;

    // 1: basic subtract, then busy must drop the cycle after done
    run_op(9, 3, 0, 6, 0);
    @(negedge clk);
    chk("lit_busy_after_fim", 8'(busy), 8'd0);

    // 2: add and hold
    run_op(2, 5, 1, 7, 0);
    repeat (10) @(negedge clk);
    chk("lit_B_hold", 8'(B), 8'd7);

    // 3: wrap cases
    run_op(3, 5, 0, 14, 1);
    run_op(12, 6, 1, 2, 1);

    // 4: zero magnitude
    run_op(5, 0, 1, 5, 1);
    run_op(5, 0, 0, 5, 0);

    // 5: start and input change while busy are ignored
    @(negedge clk);
    A = 4'd9; S = 4'd3; sinal = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd1; S = 4'd1; sinal = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'd7;
    wait_done(ok);
    if (ok) chk("lit_B_ignore", 8'(B), 8'd6);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("lit_single_done", 8'(ndone), 8'd0);

    // 6: reset mid operation
    @(negedge clk);
    A = 4'd9; S = 4'd3; sinal = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_B", 8'(B), 8'd0);
    chk("abort_erro", 8'(erro), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", 8'(ndone), 8'd0);
    run_op(15, 15, 0, 0, 0);

    // randomized soak: random operands, dense start requests, rare resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      A = W'($urandom); S = W'($urandom); sinal = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
